psc_trigger_sched: RTL and testbench

- Scheduler sitting in front of the psc_trigger serial transmitter.
- Accepts up to N EVR event trigger lines, latches each rising edge as a pending request, and grants requests round-robin.
- Applies a per-channel programmable delay, then issues a one-cycle start to the transmitter with the channel number.
- Waits on the transmitter busy handshake and enforces a minimum holdoff between frames before granting again.

---
 rtl/psc_trigger_sched.sv | 176 +++++++++++++++++
 tb/tb_psc_trigger_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psc_trigger_sched.sv
// Round-robin scheduler: latches EVR trigger edges, applies per-channel delay, then starts the psc_trigger transmitter.
// Latency: edge sampled at edge k -> pending at k, grant at k+1, tx_start at edge k+2+delay.
// Backpressure: waits on the tx_busy handshake with an ack timeout, then enforces holdoff_cfg idle cycles before the next grant.
module psc_trigger_sched #(
    parameter int N           = 4,
    parameter int CW          = 2,
    parameter int DW          = 16,
    parameter int HW          = 12,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    evr_trigger,
    input  logic [N-1:0]    chan_enable,
    input  logic [N*DW-1:0] delay_cfg,
    input  logic [HW-1:0]   holdoff_cfg,
    output logic            tx_start,
    output logic [CW-1:0]   tx_chan,
    input  logic            tx_busy,
    output logic [N-1:0]    pending,
    output logic [7:0]      overrun_cnt,
    output logic            ack_err,
    output logic            sched_busy
);

    localparam int AW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int LW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_HOLDOFF
    } state_t;

    state_t        state;
    logic [N-1:0]  prev;
    logic [CW-1:0] rr_last;
    logic [DW-1:0] dly_cnt;
    logic [AW-1:0] ack_cnt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_lim;

    logic [N-1:0]  rise;
    logic [N-1:0]  set_req;
    logic [N-1:0]  clr_req;
    logic [N-1:0]  lost;
    logic [N-1:0]  grant_oh;
    logic [N-1:0]  pending_nxt;
    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    logic [DW-1:0] grant_dly;
    logic [LW-1:0] lost_cnt;
    logic [8:0]    ovr_sum;
    logic [7:0]    overrun_nxt;
    int            srch_idx;

    assign rise    = evr_trigger & ~prev;
    assign set_req = rise & chan_enable;

    // First pending bit after rr_last, wrapping modulo N (N need not be a power of two).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        srch_idx  = 0;
        for (int k = 1; k <= N; k++) begin
            srch_idx = (int'(rr_last) + k) % N;
            if (!grant_vld && pending[srch_idx]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(srch_idx);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (state == S_IDLE && grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign grant_dly = delay_cfg[int'(grant_idx)*DW +: DW];

    // A fresh edge in the grant cycle re-arms the bit rather than counting as lost.
    assign clr_req     = grant_oh | ~chan_enable;
    assign pending_nxt = (pending & ~clr_req) | set_req;
    assign lost        = set_req & pending & ~clr_req;

    always_comb begin
        lost_cnt = '0;
        for (int i = 0; i < N; i++) begin
            lost_cnt = lost_cnt + LW'(lost[i]);
        end
    end

    assign ovr_sum     = {1'b0, overrun_cnt} + 9'(lost_cnt);
    assign overrun_nxt = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

    assign sched_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            prev        <= '0;
            pending     <= '0;
            overrun_cnt <= '0;
            ack_err     <= 1'b0;
            tx_start    <= 1'b0;
            tx_chan     <= '0;
            rr_last     <= CW'(N - 1);
            dly_cnt     <= '0;
            ack_cnt     <= '0;
            hold_cnt    <= '0;
            hold_lim    <= '0;
        end else begin
            prev        <= evr_trigger;
            pending     <= pending_nxt;
            overrun_cnt <= overrun_nxt;
            tx_start    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        tx_chan <= grant_idx;
                        rr_last <= grant_idx;
                        dly_cnt <= grant_dly;
                        state   <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == '0) begin
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                S_START: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                        // Flag on the cycle the count reaches ACK_TIMEOUT-1.
                        if (ack_cnt == AW'(ACK_TIMEOUT - 2)) begin
                            ack_err  <= 1'b1;
                            hold_cnt <= '0;
                            hold_lim <= holdoff_cfg;
                            state    <= S_HOLDOFF;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        hold_cnt <= '0;
                        hold_lim <= holdoff_cfg;
                        state    <= S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt == hold_lim) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psc_trigger_sched.sv
// Directed bench for psc_trigger_sched: a scoreboard of expected starts is checked by a free-running monitor.
module tb_psc_trigger_sched;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int DW = 16;
    localparam int HW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    evr_trigger;
    logic [N-1:0]    chan_enable;
    logic [N*DW-1:0] delay_cfg;
    logic [HW-1:0]   holdoff_cfg;
    logic            tx_start;
    logic [CW-1:0]   tx_chan;
    logic            tx_busy;
    logic [N-1:0]    pending;
    logic [7:0]      overrun_cnt;
    logic            ack_err;
    logic            sched_busy;

    logic [DW-1:0]   dly [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_chan[$];
    int exp_cyc[$];
    bit tx_auto       = 1'b1;
    int busy_len      = 50;
    int busy_fall_cyc = -1;

    psc_trigger_sched #(.N(N), .CW(CW), .DW(DW), .HW(HW), .ACK_TIMEOUT(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .evr_trigger (evr_trigger),
        .chan_enable (chan_enable),
        .delay_cfg   (delay_cfg),
        .holdoff_cfg (holdoff_cfg),
        .tx_start    (tx_start),
        .tx_chan     (tx_chan),
        .tx_busy     (tx_busy),
        .pending     (pending),
        .overrun_cnt (overrun_cnt),
        .ack_err     (ack_err),
        .sched_busy  (sched_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        delay_cfg = '0;
        for (int i = 0; i < N; i++) delay_cfg[i*DW +: DW] = dly[i];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int ch, input int t);
        exp_chan.push_back(ch);
        exp_cyc.push_back(t);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        evr_trigger = m;
        tick(1);
        evr_trigger = '0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((sched_busy !== 1'b0 || pending !== '0 || exp_chan.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(n < budget), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"},    int'(tx_start),    0);
        check({tag, "_tx_chan"},     int'(tx_chan),     0);
        check({tag, "_pending"},     int'(pending),     0);
        check({tag, "_overrun"},     int'(overrun_cnt), 0);
        check({tag, "_ack_err"},     int'(ack_err),     0);
        check({tag, "_sched_busy"},  int'(sched_busy),  0);
    endtask

    // Monitor: every start must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (exp_chan.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: chan %0d at cycle %0d, none expected", tx_chan, cyc);
                end else begin
                    int ec;
                    int et;
                    ec = exp_chan.pop_front();
                    et = exp_cyc.pop_front();
                    check("start_chan", int'(tx_chan), ec);
                    if (et >= 0) check("start_cycle", cyc, et);
                end
            end
        end
    end

    // Transmitter model: busy rises two cycles after start and holds for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && tx_auto) begin
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        reset       = 1'b1;
        evr_trigger = '0;
        chan_enable = '0;
        holdoff_cfg = '0;
        for (int i = 0; i < N; i++) dly[i] = '0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;

        // Single trigger: edge sampled at 1500, delay 100 -> start at 1602.
        chan_enable = 4'b0001;
        dly[0]      = 16'd100;
        holdoff_cfg = 12'd10;
        busy_len    = 50;
        while (cyc < 1499) tick(1);
        evr_trigger[0] = 1'b1;
        push(0, 1602);
        tick(1);
        check("single_pending_latch", int'(pending), 1);
        tick(1);
        evr_trigger = '0;
        check("single_pending_granted", int'(pending), 0);
        check("single_busy_in_delay", int'(sched_busy), 1);
        check("single_tx_chan", int'(tx_chan), 0);
        n = 0;
        while (!(sched_busy === 1'b0 && busy_fall_cyc > 0) && n < 400) begin
            tick(1);
            n++;
        end
        check("single_idle_reached", int'(n < 400), 1);
        check("single_holdoff_exit_cycle", cyc, busy_fall_cyc + 12);

        // Round-robin: two full bursts, the second landing while channel 3 is in service.
        do_reset();
        chan_enable = 4'b1111;
        for (int i = 0; i < N; i++) dly[i] = '0;
        holdoff_cfg = 12'd2;
        busy_len    = 3;
        for (int c = 0; c < N; c++) push(c, -1);
        evr_trigger = 4'b1111;
        tick(1);
        evr_trigger = '0;
        check("rr_pending_all", int'(pending), 15);
        n = 0;
        while (pending !== '0 && n < 500) begin
            tick(1);
            n++;
        end
        check("rr_first_burst_granted", int'(n < 500), 1);
        check("rr_busy_at_second_burst", int'(sched_busy), 1);
        for (int c = 0; c < N; c++) push(c, -1);
        pulse(4'b1111);
        wait_idle("rr_done", 1000);
        check("rr_no_overrun", int'(overrun_cnt), 0);

        // Overrun: channel 2 toggles while channel 1 sits in a long delay.
        dly[1] = 16'd2000;
        push(1, -1);
        pulse(4'b0010);
        tick(2);
        repeat (3) pulse(4'b0100);
        check("ovr_count_2", int'(overrun_cnt), 2);
        check("ovr_pending_ch2", int'(pending), 4);
        repeat (300) pulse(4'b0100);
        check("ovr_saturate", int'(overrun_cnt), 255);
        push(2, -1);
        wait_idle("ovr_done", 5000);

        // Handshake timeout: rr_last is 2, so channel 3 goes before channel 0.
        tx_auto = 1'b0;
        dly[0]  = '0;
        dly[3]  = '0;
        push(3, -1);
        push(0, -1);
        pulse(4'b1001);
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("to_start_seen", int'(n < 100), 1);
        s = cyc;
        check("to_ack_err_before", int'(ack_err), 0);
        n = 0;
        while (ack_err !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("to_ack_err_delay", cyc - s, 32);
        wait_idle("to_done", 500);
        check("to_ack_err_sticky", int'(ack_err), 1);
        tx_auto = 1'b1;

        // Enable gating: channel 0 keeps the FSM busy; its own disable does not abort it.
        chan_enable = 4'b0111;
        dly[0]      = 16'd200;
        push(0, -1);
        pulse(4'b0001);
        pulse(4'b1000);
        check("en_disabled_no_pending", int'(pending), 0);
        pulse(4'b0010);
        check("en_ch1_pending", int'(pending), 2);
        chan_enable[1] = 1'b0;
        tick(1);
        check("en_ch1_dropped", int'(pending), 0);
        chan_enable[0] = 1'b0;
        wait_idle("en_done", 1000);
        chan_enable = 4'b1111;

        // Reset during a 1000-cycle delay.
        dly[2] = 16'd1000;
        pulse(4'b0100);
        tick(50);
        check("rst_busy_in_delay", int'(sched_busy), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_all_zero("rst_mid");
        tick(1100);
        check("rst_stays_idle", int'(sched_busy), 0);
        dly[0] = '0;
        dly[3] = '0;
        push(0, -1);
        push(3, -1);
        pulse(4'b1001);
        wait_idle("rst_fresh_done", 500);

        check("scoreboard_empty", exp_chan.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
